nway_cache_ctrl: RTL and testbench

Parametrised N-way set-associative write-back cache controller; successor to the fixed 2-way controller. Sits between the processor memory stage and the banked main memory, driving per-way enable/write strobes on the cache data arrays. Adds configurable ways, line length and memory latency, invalid-way-first plus round-robin replacement, and mem_stall back-pressure during write-back and fill.

---
 rtl/cache_pkg.sv | 24 ++
 rtl/cache_victim_sel.sv | 42 ++++
 rtl/nway_cache_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_nway_cache_ctrl.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the N-way cache controller.
//   state_e   : controller FSM states
//   way_w_f   : width of a way index (at least one bit, even for a single way)
//   off_w_f   : width of the byte offset field for a line of 16-bit words
package cache_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCompare,
        StWb,
        StFill,
        StWrAlloc,
        StDoneRd
    } state_e;

    function automatic int unsigned way_w_f(input int unsigned ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    function automatic int unsigned off_w_f(input int unsigned words);
        return $clog2(words) + 1;
    endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// Victim way selection: the lowest-index invalid way if any, otherwise the
// round-robin pointer. The pointer advances by one (mod WAYS) on 'advance'.
//   clk, rst : clock, synchronous active-high reset (pointer to 0)
//   valid    : per-way valid bits of the addressed set
//   advance  : step the round-robin pointer
//   victim   : selected way index
module cache_victim_sel
    import cache_pkg::*;
#(
    parameter int unsigned WAYS = 2,
    localparam int unsigned WAY_W = way_w_f(WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WAYS-1:0]  valid,
    input  logic             advance,
    output logic [WAY_W-1:0] victim
);

    logic [WAY_W-1:0] rr_q, rr_d;

    // Scan downwards so the lowest invalid way is the one left standing.
    always_comb begin
        victim = rr_q;
        for (int k = int'(WAYS) - 1; k >= 0; k--) begin
            if (!valid[k]) victim = WAY_W'(k);
        end
    end

    // WAYS is a power of two, so the natural wrap of the pointer is mod WAYS;
    // a single way keeps the pointer pinned at 0.
    always_comb begin
        rr_d = rr_q;
        if (advance && WAYS > 1) rr_d = rr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) rr_q <= '0;
        else     rr_q <= rr_d;
    end

endmodule

// File: rtl/nway_cache_ctrl.sv
// N-way set-associative write-back cache controller.
//   clk, rst             : clock, synchronous active-high reset
//   addr, rd, wr         : processor request (wr wins if both high)
//   done, cache_hit      : completion pulse, hit qualifier
//   stall_out            : processor stall
//   sel, write_sel       : read/write-back way select, data-in source (1 = cpu)
//   comp, valid_in       : array compare mode, valid bit to write
//   cache_tag/index      : address fields to the arrays; offset: word offset
//   way_en, way_wr       : per-way enable / write strobes
//   tag_in, hit, dirty, valid : per-way status from the arrays
//   mem_addr, mem_rd, mem_wr, mem_stall : main memory interface
module nway_cache_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned WAYS    = 2,
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned INDEX_W = 8,
    parameter int unsigned WORDS   = 4,
    parameter int unsigned MEM_LAT = 2,
    localparam int unsigned OFF_W  = off_w_f(WORDS),
    localparam int unsigned ADDR_W = TAG_W + INDEX_W + OFF_W,
    localparam int unsigned WAY_W  = way_w_f(WAYS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     addr,
    input  logic                  rd,
    input  logic                  wr,
    output logic                  done,
    output logic                  cache_hit,
    output logic                  stall_out,
    output logic [WAY_W-1:0]      sel,
    output logic                  write_sel,
    output logic                  comp,
    output logic                  valid_in,
    output logic [TAG_W-1:0]      cache_tag,
    output logic [INDEX_W-1:0]    cache_index,
    output logic [OFF_W-1:0]      offset,
    output logic [WAYS-1:0]       way_en,
    output logic [WAYS-1:0]       way_wr,
    input  logic [WAYS*TAG_W-1:0] tag_in,
    input  logic [WAYS-1:0]       hit,
    input  logic [WAYS-1:0]       dirty,
    input  logic [WAYS-1:0]       valid,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    input  logic                  mem_stall
);

    localparam logic [OFF_W-1:0] WordsC   = OFF_W'(WORDS);
    localparam logic [OFF_W-1:0] LastWord = OFF_W'(WORDS - 1);

    state_e               state_q, state_d;
    logic [WAY_W-1:0]     victim_q, victim_d;
    logic [OFF_W-1:0]     wb_cnt_q, wb_cnt_d;
    logic [OFF_W-1:0]     rd_cnt_q, rd_cnt_d;
    logic [OFF_W-1:0]     wr_cnt_q, wr_cnt_d;
    // Bit i set = a read accepted i+1 cycles ago; the top bit marks returning data.
    logic [MEM_LAT-1:0]   pipe_q, pipe_d;

    logic [WAY_W-1:0]     victim_new;
    logic [WAYS-1:0]      hit_vec, hit_oh, victim_oh;
    logic [WAY_W-1:0]     hit_way;
    logic                 hit_any;
    logic [TAG_W-1:0]     victim_tag;
    logic                 rd_acc;

    // Word counter to byte offset within the line.
    function automatic logic [OFF_W-1:0] word_off(input logic [OFF_W-1:0] cnt);
        return {cnt[OFF_W-2:0], 1'b0};
    endfunction

    assign cache_tag   = addr[ADDR_W-1 -: TAG_W];
    assign cache_index = addr[OFF_W +: INDEX_W];
    assign victim_oh   = WAYS'(1) << victim_q;
    assign victim_tag  = tag_in[victim_q*TAG_W +: TAG_W];

    cache_victim_sel #(
        .WAYS (WAYS)
    ) u_victim_sel (
        .clk     (clk),
        .rst     (rst),
        .valid   (valid),
        .advance (state_q == StDoneRd),
        .victim  (victim_new)
    );

    // Lowest-index qualified hit wins.
    always_comb begin
        hit_vec = hit & valid;
        hit_any = |hit_vec;
        hit_way = '0;
        hit_oh  = '0;
        for (int k = int'(WAYS) - 1; k >= 0; k--) begin
            if (hit_vec[k]) begin
                hit_way   = WAY_W'(k);
                hit_oh    = '0;
                hit_oh[k] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        victim_d  = victim_q;
        wb_cnt_d  = wb_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        pipe_d    = pipe_q;
        rd_acc    = 1'b0;
        done      = 1'b0;
        cache_hit = 1'b0;
        stall_out = 1'b0;
        sel       = '0;
        write_sel = 1'b1;
        comp      = 1'b0;
        valid_in  = 1'b0;
        offset    = addr[OFF_W-1:0];
        way_en    = '0;
        way_wr    = '0;
        mem_addr  = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;

        // While rst is high every output stays at its quiet default.
        if (!rst) begin
            case (state_q)
                StIdle: begin
                    if (rd || wr) begin
                        stall_out = 1'b1;
                        state_d   = StCompare;
                    end
                end

                StCompare: begin
                    way_en = '1;
                    comp   = 1'b1;
                    if (hit_any) begin
                        sel       = hit_way;
                        done      = 1'b1;
                        cache_hit = 1'b1;
                        if (wr) begin
                            way_wr   = hit_oh;
                            valid_in = 1'b1;
                        end
                        state_d = StIdle;
                    end else begin
                        stall_out = 1'b1;
                        victim_d  = victim_new;
                        wb_cnt_d  = '0;
                        rd_cnt_d  = '0;
                        wr_cnt_d  = '0;
                        pipe_d    = '0;
                        state_d   = (dirty[victim_new] && valid[victim_new]) ? StWb : StFill;
                    end
                end

                StWb: begin
                    stall_out = 1'b1;
                    way_en    = victim_oh;
                    sel       = victim_q;
                    offset    = word_off(wb_cnt_q);
                    mem_addr  = {victim_tag, cache_index, word_off(wb_cnt_q)};
                    mem_wr    = 1'b1;
                    if (!mem_stall) begin
                        wb_cnt_d = wb_cnt_q + 1'b1;
                        if (wb_cnt_q == LastWord) state_d = StFill;
                    end
                end

                StFill: begin
                    stall_out = 1'b1;
                    way_en    = victim_oh;
                    sel       = victim_q;
                    mem_addr  = {cache_tag, cache_index, word_off(rd_cnt_q)};
                    if (rd_cnt_q < WordsC) begin
                        mem_rd = 1'b1;
                        rd_acc = !mem_stall;
                    end
                    if (rd_acc) rd_cnt_d = rd_cnt_q + 1'b1;
                    pipe_d = (pipe_q << 1) | MEM_LAT'(rd_acc);
                    if (pipe_q[MEM_LAT-1]) begin
                        way_wr    = victim_oh;
                        write_sel = 1'b0;
                        offset    = word_off(wr_cnt_q);
                        valid_in  = 1'b1;
                        wr_cnt_d  = wr_cnt_q + 1'b1;
                        if (wr_cnt_q == LastWord) state_d = wr ? StWrAlloc : StDoneRd;
                    end
                end

                // Write the processor word into the fresh line; comp=1 marks it dirty.
                StWrAlloc: begin
                    stall_out = 1'b1;
                    way_en    = victim_oh;
                    way_wr    = victim_oh;
                    sel       = victim_q;
                    comp      = 1'b1;
                    valid_in  = 1'b1;
                    state_d   = StDoneRd;
                end

                StDoneRd: begin
                    way_en  = victim_oh;
                    sel     = victim_q;
                    done    = 1'b1;
                    state_d = StIdle;
                end

                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            victim_q <= '0;
            wb_cnt_q <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            pipe_q   <= '0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            wb_cnt_q <= wb_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            pipe_q   <= pipe_d;
        end
    end

endmodule

// File: tb/tb_nway_cache_ctrl.sv
module tb_nway_cache_ctrl;

    localparam int unsigned WAYS    = 2;
    localparam int unsigned TAG_W   = 5;
    localparam int unsigned INDEX_W = 8;
    localparam int unsigned WORDS   = 4;
    localparam int unsigned MEM_LAT = 2;
    localparam int unsigned OFF_W   = 3;
    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned WAY_W   = 1;
    localparam int unsigned NSETS   = 256;

    logic                  clk, rst;
    logic [ADDR_W-1:0]     addr;
    logic                  rd, wr;
    logic                  done, cache_hit, stall_out;
    logic [WAY_W-1:0]      sel;
    logic                  write_sel, comp, valid_in;
    logic [TAG_W-1:0]      cache_tag;
    logic [INDEX_W-1:0]    cache_index;
    logic [OFF_W-1:0]      offset;
    logic [WAYS-1:0]       way_en, way_wr;
    logic [WAYS*TAG_W-1:0] tag_in;
    logic [WAYS-1:0]       hit, dirty, valid;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_rd, mem_wr, mem_stall;

    // Behavioural model of the tag/status arrays and the replacement pointer.
    logic [TAG_W-1:0] m_tag [WAYS][NSETS];
    bit               m_val [WAYS][NSETS];
    bit               m_dty [WAYS][NSETS];
    int               m_rr;

    int n_vec = 0;
    int n_err = 0;

    nway_cache_ctrl #(
        .WAYS    (WAYS),
        .TAG_W   (TAG_W),
        .INDEX_W (INDEX_W),
        .WORDS   (WORDS),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .addr        (addr),
        .rd          (rd),
        .wr          (wr),
        .done        (done),
        .cache_hit   (cache_hit),
        .stall_out   (stall_out),
        .sel         (sel),
        .write_sel   (write_sel),
        .comp        (comp),
        .valid_in    (valid_in),
        .cache_tag   (cache_tag),
        .cache_index (cache_index),
        .offset      (offset),
        .way_en      (way_en),
        .way_wr      (way_wr),
        .tag_in      (tag_in),
        .hit         (hit),
        .dirty       (dirty),
        .valid       (valid),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_stall   (mem_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arrays answer for the set addressed by the processor; hit is a raw tag match.
    always_comb begin
        tag_in = '0;
        valid  = '0;
        dirty  = '0;
        hit    = '0;
        for (int k = 0; k < int'(WAYS); k++) begin
            tag_in[k*TAG_W +: TAG_W] = m_tag[k][addr[OFF_W +: INDEX_W]];
            valid[k] = m_val[k][addr[OFF_W +: INDEX_W]];
            dirty[k] = m_dty[k][addr[OFF_W +: INDEX_W]];
            hit[k]   = (m_tag[k][addr[OFF_W +: INDEX_W]] == addr[ADDR_W-1 -: TAG_W]);
        end
    end

    task automatic clear_model();
        for (int k = 0; k < int'(WAYS); k++)
            for (int s = 0; s < int'(NSETS); s++) begin
                m_tag[k][s] = '0;
                m_val[k][s] = 1'b0;
                m_dty[k][s] = 1'b0;
            end
        m_rr = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; rd = 1'b0; wr = 1'b0; mem_stall = 1'b0; addr = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_rr = 0;
    endtask

    task automatic set_line(input int w, input int ix, input logic [TAG_W-1:0] t,
                            input bit v, input bit d);
        m_tag[w][ix] = t;
        m_val[w][ix] = v;
        m_dty[w][ix] = d;
    endtask

    // One processor access from IDLE to done. stall_mode: 0 none, 1 random,
    // 2 stall in cycles 3..5. exp_done < 0 means no fixed latency expected.
    task automatic run_txn(input logic [ADDR_W-1:0] a, input bit is_wr,
                           input int stall_mode, input int exp_done);
        logic [TAG_W-1:0]   t, wb_tag;
        logic [INDEX_W-1:0] ix;
        logic [WAYS-1:0]    voh, hoh;
        logic [ADDR_W-1:0]  ea;
        logic [OFF_W-1:0]   eo;
        int hw, vic, n_wb, cyc, wb_i, rd_i, wr_i, last_acc, calc, acc_t;
        bit is_dirty, finished, alloc_seen;
        int acc_q[$];

        t  = a[ADDR_W-1 -: TAG_W];
        ix = a[OFF_W +: INDEX_W];
        hw = -1;
        for (int k = int'(WAYS) - 1; k >= 0; k--)
            if (m_val[k][ix] && m_tag[k][ix] == t) hw = k;
        vic = m_rr;
        for (int k = int'(WAYS) - 1; k >= 0; k--)
            if (!m_val[k][ix]) vic = k;
        is_dirty = (hw < 0) && m_val[vic][ix] && m_dty[vic][ix];
        wb_tag   = m_tag[vic][ix];
        n_wb     = is_dirty ? int'(WORDS) : 0;
        voh      = WAYS'(1) << vic;
        hoh      = (hw >= 0) ? (WAYS'(1) << hw) : '0;

        cyc = 0; wb_i = 0; rd_i = 0; wr_i = 0; last_acc = -1;
        finished = 1'b0; alloc_seen = 1'b0;
        addr = a; rd = !is_wr; wr = is_wr;

        while (!finished && cyc < 300) begin
            case (stall_mode)
                1:       mem_stall = ($urandom_range(0, 3) == 0);
                2:       mem_stall = (cyc >= 3 && cyc <= 5);
                default: mem_stall = 1'b0;
            endcase
            @(negedge clk);

            n_vec++;
            if (stall_out !== !done) begin
                n_err++;
                $display("FAIL stall_out cyc%0d: got %b want %b", cyc, stall_out, !done);
            end

            if (mem_wr === 1'b1 && mem_stall === 1'b0) begin
                ea = {wb_tag, ix, OFF_W'(2 * wb_i)};
                n_vec++;
                if (wb_i >= n_wb || mem_addr !== ea) begin
                    n_err++;
                    $display("FAIL wb_addr cyc%0d word%0d: got %h want %h (wb expected %0d)",
                             cyc, wb_i, mem_addr, ea, n_wb);
                end
                wb_i++;
            end

            if (mem_rd === 1'b1 && mem_stall === 1'b0) begin
                ea = {t, ix, OFF_W'(2 * rd_i)};
                n_vec++;
                if (hw >= 0 || rd_i >= int'(WORDS) || wb_i != n_wb || mem_addr !== ea) begin
                    n_err++;
                    $display("FAIL rd_addr cyc%0d word%0d: got %h want %h", cyc, rd_i, mem_addr, ea);
                end
                acc_q.push_back(cyc);
                last_acc = cyc;
                rd_i++;
            end

            if (way_wr !== '0 && done !== 1'b1) begin
                n_vec++;
                if (write_sel === 1'b0) begin
                    eo    = OFF_W'(2 * wr_i);
                    acc_t = (acc_q.size() > 0) ? acc_q.pop_front() : -100;
                    if (way_wr !== voh || offset !== eo || valid_in !== 1'b1 ||
                        comp !== 1'b0 || cyc != acc_t + int'(MEM_LAT)) begin
                        n_err++;
                        $display("FAIL fill_wr cyc%0d: got way_wr=%b off=%0d want way_wr=%b off=%0d at cyc%0d",
                                 cyc, way_wr, offset, voh, eo, acc_t + int'(MEM_LAT));
                    end
                    wr_i++;
                end else begin
                    if (!is_wr || hw >= 0 || wr_i != int'(WORDS) || way_wr !== voh ||
                        offset !== a[OFF_W-1:0] || comp !== 1'b1) begin
                        n_err++;
                        $display("FAIL wr_alloc cyc%0d: got way_wr=%b off=%0d comp=%b want way_wr=%b off=%0d comp=1",
                                 cyc, way_wr, offset, comp, voh, a[OFF_W-1:0]);
                    end
                    alloc_seen = 1'b1;
                end
            end

            if (done === 1'b1) begin
                finished = 1'b1;
                calc = (hw >= 0) ? 1 : last_acc + int'(MEM_LAT) + 1 + int'(is_wr);
                n_vec++;
                if (cyc != calc || (exp_done >= 0 && cyc != exp_done)) begin
                    n_err++;
                    $display("FAIL done_cycle: got %0d want %0d (fixed %0d)", cyc, calc, exp_done);
                end
                n_vec++;
                if (cache_hit !== (hw >= 0)) begin
                    n_err++;
                    $display("FAIL cache_hit: got %b want %b", cache_hit, hw >= 0);
                end
                n_vec++;
                if (sel !== WAY_W'((hw >= 0) ? hw : vic)) begin
                    n_err++;
                    $display("FAIL sel: got %0d want %0d", sel, (hw >= 0) ? hw : vic);
                end
                n_vec++;
                if (way_wr !== ((hw >= 0 && is_wr) ? hoh : '0)) begin
                    n_err++;
                    $display("FAIL done_way_wr: got %b want %b", way_wr,
                             (hw >= 0 && is_wr) ? hoh : '0);
                end
                if (hw < 0) begin
                    n_vec++;
                    if (wr_i != int'(WORDS) || wb_i != n_wb || alloc_seen != is_wr ||
                        way_en !== voh) begin
                        n_err++;
                        $display("FAIL miss_totals: got wr=%0d wb=%0d alloc=%b en=%b want %0d %0d %b %b",
                                 wr_i, wb_i, alloc_seen, way_en, WORDS, n_wb, is_wr, voh);
                    end
                end
                rd = 1'b0; wr = 1'b0;
            end else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        mem_stall = 1'b0;
        if (!finished) begin
            n_vec++; n_err++;
            $display("FAIL txn_timeout: got no done want done for addr %h", a);
            rd = 1'b0; wr = 1'b0;
        end
        // Model update from the replacement rules.
        if (hw >= 0) begin
            if (is_wr) m_dty[hw][ix] = 1'b1;
        end else begin
            set_line(vic, int'(ix), t, 1'b1, is_wr);
            m_rr = (m_rr + 1) % int'(WAYS);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rd = 1'b1; wr = 1'b0; mem_stall = 1'b0; addr = 16'hA5A5;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({done, cache_hit, stall_out, mem_rd, mem_wr} !== 5'b0) begin
            n_err++;
            $display("FAIL rst_ctrl: got %b want 00000", {done, cache_hit, stall_out, mem_rd, mem_wr});
        end
        n_vec++;
        if (way_en !== '0 || way_wr !== '0) begin
            n_err++;
            $display("FAIL rst_strobes: got en=%b wr=%b want 0", way_en, way_wr);
        end
        n_vec++;
        if (write_sel !== 1'b1) begin
            n_err++;
            $display("FAIL rst_write_sel: got %b want 1", write_sel);
        end
        n_vec++;
        if (offset !== 3'b101 || cache_tag !== 5'h14 || cache_index !== 8'hB4) begin
            n_err++;
            $display("FAIL rst_fields: got %h/%h/%h want 5/14/b4", offset, cache_tag, cache_index);
        end
        rd = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        m_rr = 0;
    endtask

    task automatic test_read_hit();
        clear_model(); do_reset();
        set_line(0, 8'h10, 5'h1c, 1'b1, 1'b0);
        set_line(1, 8'h10, 5'h03, 1'b1, 1'b0);
        run_txn({5'h03, 8'h10, 3'b010}, 1'b0, 0, 1);
        run_txn({5'h03, 8'h10, 3'b100}, 1'b1, 0, 1);
    endtask

    task automatic test_clean_miss();
        clear_model(); do_reset();
        set_line(0, 8'h22, 5'h01, 1'b1, 1'b0);
        set_line(1, 8'h22, 5'h02, 1'b1, 1'b0);
        run_txn({5'h09, 8'h22, 3'b000}, 1'b0, 0, 8);
        run_txn({5'h0a, 8'h22, 3'b010}, 1'b0, 0, 8);
    endtask

    task automatic test_dirty_miss();
        clear_model(); do_reset();
        set_line(0, 8'h33, 5'h07, 1'b1, 1'b1);
        set_line(1, 8'h33, 5'h04, 1'b1, 1'b0);
        run_txn({5'h11, 8'h33, 3'b100}, 1'b0, 0, 12);
    endtask

    task automatic test_write_miss();
        clear_model(); do_reset();
        set_line(0, 8'h44, 5'h01, 1'b1, 1'b0);
        run_txn({5'h05, 8'h44, 3'b110}, 1'b1, 0, 9);
        set_line(0, 8'h45, 5'h01, 1'b1, 1'b0);
        set_line(1, 8'h45, 5'h02, 1'b1, 1'b0);
        run_txn({5'h06, 8'h45, 3'b000}, 1'b0, 0, 8);
    endtask

    task automatic test_fill_stall();
        clear_model(); do_reset();
        set_line(0, 8'h55, 5'h01, 1'b1, 1'b0);
        set_line(1, 8'h55, 5'h02, 1'b1, 1'b0);
        run_txn({5'h0b, 8'h55, 3'b000}, 1'b0, 2, 11);
    endtask

    task automatic test_reset_mid_fill();
        clear_model(); do_reset();
        set_line(0, 8'h66, 5'h01, 1'b1, 1'b0);
        set_line(1, 8'h66, 5'h02, 1'b1, 1'b0);
        run_txn({5'h0c, 8'h66, 3'b000}, 1'b0, 0, 8);
        addr = {5'h0d, 8'h66, 3'b000}; rd = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if (way_wr !== '0 || mem_rd !== 1'b0 || stall_out !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL rst_fill_outs: got wr=%b rd=%b st=%b dn=%b want 0", way_wr, mem_rd,
                     stall_out, done);
        end
        rd = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        m_rr = 0;
        @(negedge clk);
        n_vec++;
        if (way_en !== '0 || mem_rd !== 1'b0 || stall_out !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL rst_fill_idle: got en=%b rd=%b st=%b dn=%b want 0", way_en, mem_rd,
                     stall_out, done);
        end
        @(posedge clk);
        #1;
        run_txn({5'h0d, 8'h66, 3'b000}, 1'b0, 0, 8);
    endtask

    task automatic test_random();
        logic [TAG_W-1:0]   t;
        logic [INDEX_W-1:0] ix;
        logic [OFF_W-1:0]   o;
        clear_model(); do_reset();
        for (int s = 8'h70; s <= 8'h73; s++)
            for (int k = 0; k < int'(WAYS); k++)
                set_line(k, s, TAG_W'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)));
        for (int n = 0; n < 40; n++) begin
            t  = TAG_W'($urandom_range(0, 3));
            ix = INDEX_W'(8'h70 + $urandom_range(0, 3));
            o  = OFF_W'($urandom_range(0, 7));
            run_txn({t, ix, o}, 1'($urandom_range(0, 1)), 1, -1);
        end
    endtask

    initial begin
        clear_model();
        test_reset();
        test_read_hit();
        test_clean_miss();
        test_dirty_miss();
        test_write_miss();
        test_fill_stall();
        test_reset_mid_fill();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
